// File: rtl/cache_arbiter_if.sv
// rtl/cache_arbiter_if.sv - cache/pmem bus bundle for cache_arbiter
// slave is the arbiter's view; master is the caches-plus-memory environment.
interface cache_arbiter_if #(
    parameter int LINE_WIDTH = 256,
    parameter int ADDR_WIDTH = 32
);
    logic                  i_read;
    logic [ADDR_WIDTH-1:0] i_address;
    logic [LINE_WIDTH-1:0] i_rdata;
    logic                  i_resp;

    logic                  d_read;
    logic                  d_write;
    logic [ADDR_WIDTH-1:0] d_address;
    logic [LINE_WIDTH-1:0] d_wdata;
    logic [LINE_WIDTH-1:0] d_rdata;
    logic                  d_resp;

    logic                  pmem_read;
    logic                  pmem_write;
    logic [ADDR_WIDTH-1:0] pmem_address;
    logic [LINE_WIDTH-1:0] pmem_wdata;
    logic [LINE_WIDTH-1:0] pmem_rdata;
    logic                  pmem_resp;

    modport slave (
        input  i_read, i_address, d_read, d_write, d_address, d_wdata,
        input  pmem_rdata, pmem_resp,
        output i_rdata, i_resp, d_rdata, d_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata
    );

    modport master (
        output i_read, i_address, d_read, d_write, d_address, d_wdata,
        output pmem_rdata, pmem_resp,
        input  i_rdata, i_resp, d_rdata, d_resp,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata
    );
endinterface

// File: rtl/cache_arbiter.sv
// rtl/cache_arbiter.sv - icache/dcache arbiter for a single cacheline pmem port
// Optional round-robin priority when CACHE_ARBITER_RR_EN is defined; fixed dcache priority otherwise.
module cache_arbiter #(
    parameter int LINE_WIDTH = 256,
    parameter int ADDR_WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    cache_arbiter_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, MEM, DONE} state_t;
    typedef enum logic {OWN_I, OWN_D} owner_t;

    state_t                state_q;
    owner_t                owner_q;
    logic                  pmem_read_q;
    logic                  pmem_write_q;
    logic [ADDR_WIDTH-1:0] pmem_address_q;
    logic [LINE_WIDTH-1:0] pmem_wdata_q;
    logic                  i_resp_q;
    logic                  d_resp_q;
    logic [LINE_WIDTH-1:0] i_rdata_q;
    logic [LINE_WIDTH-1:0] d_rdata_q;
`ifdef CACHE_ARBITER_RR_EN
    owner_t                rr_last_q;
`endif

    logic d_req;
    logic i_req;
    logic pick_d;

    always_comb begin
        d_req = bus.d_read | bus.d_write;
        i_req = bus.i_read;
`ifdef CACHE_ARBITER_RR_EN
        pick_d = d_req && (!i_req || rr_last_q == OWN_I);
`else
        pick_d = d_req;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            owner_q        <= OWN_I;
            pmem_read_q    <= 1'b0;
            pmem_write_q   <= 1'b0;
            pmem_address_q <= '0;
            pmem_wdata_q   <= '0;
            i_resp_q       <= 1'b0;
            d_resp_q       <= 1'b0;
            i_rdata_q      <= '0;
            d_rdata_q      <= '0;
`ifdef CACHE_ARBITER_RR_EN
            rr_last_q      <= OWN_I;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    i_resp_q <= 1'b0;
                    d_resp_q <= 1'b0;
                    if (pick_d) begin
                        // A simultaneous d_read is overridden: write wins.
                        owner_q        <= OWN_D;
                        pmem_address_q <= bus.d_address;
                        pmem_write_q   <= bus.d_write;
                        pmem_read_q    <= ~bus.d_write;
                        if (bus.d_write) pmem_wdata_q <= bus.d_wdata;
                        state_q        <= MEM;
                    end else if (i_req) begin
                        owner_q        <= OWN_I;
                        pmem_address_q <= bus.i_address;
                        pmem_read_q    <= 1'b1;
                        pmem_write_q   <= 1'b0;
                        state_q        <= MEM;
                    end else begin
                        pmem_read_q    <= 1'b0;
                        pmem_write_q   <= 1'b0;
                    end
                end
                MEM: begin
                    if (bus.pmem_resp) begin
                        pmem_read_q  <= 1'b0;
                        pmem_write_q <= 1'b0;
                        if (pmem_read_q) begin
                            if (owner_q == OWN_D) d_rdata_q <= bus.pmem_rdata;
                            else                  i_rdata_q <= bus.pmem_rdata;
                        end
                        if (owner_q == OWN_D) d_resp_q <= 1'b1;
                        else                  i_resp_q <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    // Requests are ignored here so a just-released cache is not re-granted on a stale level.
                    i_resp_q <= 1'b0;
                    d_resp_q <= 1'b0;
`ifdef CACHE_ARBITER_RR_EN
                    rr_last_q <= owner_q;
`endif
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.pmem_read    = pmem_read_q;
    assign bus.pmem_write   = pmem_write_q;
    assign bus.pmem_address = pmem_address_q;
    assign bus.pmem_wdata   = pmem_wdata_q;
    assign bus.i_resp       = i_resp_q;
    assign bus.d_resp       = d_resp_q;
    assign bus.i_rdata      = i_rdata_q;
    assign bus.d_rdata      = d_rdata_q;
endmodule

// File: tb/tb_cache_arbiter.sv
// tb/tb_cache_arbiter.sv - self-checking bench for cache_arbiter
// Expected grants come from a requester-level model: who is pending, and who was served last.
module tb_cache_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    cache_arbiter_if #(.LINE_WIDTH(256), .ADDR_WIDTH(32)) bus ();

    cache_arbiter #(.LINE_WIDTH(256), .ADDR_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    bit           pend_i, pend_d, d_is_write, last_was_d;
    logic [31:0]  m_iaddr, m_daddr;
    logic [255:0] m_dwdata, exp_irdata, exp_drdata;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic req_i(input logic [31:0] a);
        bus.i_read = 1'b1; bus.i_address = a;
        pend_i = 1'b1; m_iaddr = a;
    endtask

    task automatic req_d(input bit rd, input bit wr, input logic [31:0] a, input logic [255:0] wd);
        bus.d_read = rd; bus.d_write = wr; bus.d_address = a; bus.d_wdata = wd;
        pend_d = 1'b1; d_is_write = wr; m_daddr = a; m_dwdata = wd;
        if (rd && wr) $display("note: d_read and d_write both high (illegal), write expected");
    endtask

    task automatic drop_i();
        bus.i_read = 1'b0; pend_i = 1'b0;
    endtask

    task automatic drop_d();
        bus.d_read = 1'b0; bus.d_write = 1'b0; pend_d = 1'b0;
    endtask

    // Called right after the negedge where requests became pending; returns at the negedge after resp.
    // release_mode: 0 drop winner, 1 keep both, 2 drop both. raise_d raises a new dcache read mid-MEM.
    task automatic serve(input int lat, input logic [255:0] rd, input int release_mode, input bit raise_d);
        bit           win_d, ew;
        logic [31:0]  ea;
        if (pend_d && pend_i) begin
`ifdef CACHE_ARBITER_RR_EN
            win_d = !last_was_d;
`else
            win_d = 1'b1;
`endif
        end else begin
            win_d = pend_d;
        end
        ew = win_d && d_is_write;
        ea = win_d ? m_daddr : m_iaddr;

        @(negedge clk);
        chk("grant_op", {bus.pmem_read, bus.pmem_write}, {!ew, ew});
        chk("grant_addr", bus.pmem_address, ea);
        if (ew) chk("grant_wdata", bus.pmem_wdata, m_dwdata);
        if (raise_d) req_d(1'b1, 1'b0, $urandom & 32'hFFFF_FFE0, '0);
        for (int c = 0; c < lat; c++) begin
            @(negedge clk);
            chk("hold_op", {bus.pmem_read, bus.pmem_write}, {!ew, ew});
            chk("hold_addr", bus.pmem_address, ea);
            chk("hold_resp", {bus.i_resp, bus.d_resp}, 2'b00);
        end
        bus.pmem_resp = 1'b1; bus.pmem_rdata = rd;

        @(negedge clk);
        bus.pmem_resp = 1'b0;
        if (!ew) begin
            if (win_d) exp_drdata = rd;
            else       exp_irdata = rd;
        end
        last_was_d = win_d;
        chk("resp_i", bus.i_resp, !win_d);
        chk("resp_d", bus.d_resp, win_d);
        chk("rdata_i", bus.i_rdata, exp_irdata);
        chk("rdata_d", bus.d_rdata, exp_drdata);
        chk("done_idle_op", {bus.pmem_read, bus.pmem_write}, 2'b00);
        if (release_mode == 2) begin
            drop_i(); drop_d();
        end else if (release_mode == 0) begin
            if (win_d) drop_d();
            else       drop_i();
        end

        @(negedge clk);
        chk("resp_pulse_end", {bus.i_resp, bus.d_resp}, 2'b00);
    endtask

    initial begin
        rst = 1'b1;
        bus.i_read = 1'b0; bus.i_address = '0;
        bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_address = '0; bus.d_wdata = '0;
        bus.pmem_rdata = '0; bus.pmem_resp = 1'b0;
        pend_i = 0; pend_d = 0; d_is_write = 0; last_was_d = 0;
        m_iaddr = '0; m_daddr = '0; m_dwdata = '0; exp_irdata = '0; exp_drdata = '0;

        repeat (3) @(negedge clk);
        chk("rst_pmem_op", {bus.pmem_read, bus.pmem_write}, 2'b00);
        chk("rst_pmem_addr", bus.pmem_address, 32'h0);
        chk("rst_pmem_wdata", bus.pmem_wdata, '0);
        chk("rst_resp", {bus.i_resp, bus.d_resp}, 2'b00);
        chk("rst_i_rdata", bus.i_rdata, '0);
        chk("rst_d_rdata", bus.d_rdata, '0);
        rst = 1'b0;
        @(negedge clk);

        // Lone icache fill, memory answers on the third MEM cycle.
        req_i(32'h0000_0060);
        serve(2, {32{8'hA5}}, 0, 1'b0);

        // Dcache writeback leaves d_rdata alone.
        req_d(1'b0, 1'b1, 32'h0000_1000, {4{64'h0123_4567_89AB_CDEF}});
        serve(3, rand_line(), 0, 1'b0);

        // Contention raised in the same cycle.
        req_i(32'h0000_2040);
        req_d(1'b1, 1'b0, 32'h0000_3080, '0);
        serve(1, rand_line(), 0, 1'b0);
        serve(1, rand_line(), 0, 1'b0);

        // Both held continuously for four transactions.
        last_was_d = 1'b0;
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        exp_irdata = '0; exp_drdata = '0;
        req_i(32'h0000_4000);
        req_d(1'b1, 1'b0, 32'h0000_5000, '0);
        serve(0, rand_line(), 1, 1'b0);
        serve(1, rand_line(), 1, 1'b0);
        serve(2, rand_line(), 1, 1'b0);
        serve(0, rand_line(), 2, 1'b0);

        // Dcache request appears while icache owns memory.
        req_i(32'h0000_6020);
        serve(3, rand_line(), 0, 1'b1);
        serve(1, rand_line(), 0, 1'b0);

        // Stray pmem_resp in IDLE must not produce a response.
        bus.pmem_resp = 1'b1; bus.pmem_rdata = rand_line();
        @(negedge clk);
        bus.pmem_resp = 1'b0;
        chk("stray_resp", {bus.i_resp, bus.d_resp}, 2'b00);
        chk("stray_rdata_i", bus.i_rdata, exp_irdata);
        @(negedge clk);
        chk("stray_idle", {bus.pmem_read, bus.pmem_write}, 2'b00);

        // Illegal read+write: write wins.
        req_d(1'b1, 1'b1, 32'h0000_7000, rand_line());
        serve(1, rand_line(), 0, 1'b0);

        // Reset two cycles into MEM.
        req_i(32'h0000_8000);
        @(negedge clk);
        chk("pre_rst_read", bus.pmem_read, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drop_i();
        exp_irdata = '0; exp_drdata = '0; last_was_d = 1'b0;
        chk("mid_rst_op", {bus.pmem_read, bus.pmem_write}, 2'b00);
        chk("mid_rst_resp", {bus.i_resp, bus.d_resp}, 2'b00);
        chk("mid_rst_rdata_d", bus.d_rdata, '0);
        @(negedge clk);
        chk("post_rst_idle", {bus.pmem_read, bus.pmem_write}, 2'b00);
        req_d(1'b1, 1'b0, 32'h0000_9040, '0);
        serve(2, rand_line(), 0, 1'b0);

        // Randomized traffic.
        for (int t = 0; t < 20; t++) begin
            int mode;
            mode = $urandom_range(1, 3);
            if (mode != 2) req_i($urandom & 32'hFFFF_FFE0);
            if (mode != 1) begin
                bit w;
                w = $urandom_range(0, 1) == 1;
                req_d(!w, w, $urandom & 32'hFFFF_FFE0, rand_line());
            end
            serve($urandom_range(0, 4), rand_line(), 0, 1'b0);
            if (pend_i || pend_d) serve($urandom_range(0, 4), rand_line(), 0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cache_arbiter.md
Name: cache_arbiter

Overview:
- Shares the single cacheline-wide physical memory port between the instruction cache (IF-stage misses) and the data cache (MEM-stage misses and writebacks).
- Sits between the two caches and pmem. One transaction is outstanding at a time.
- Grants, registers the request, holds the pmem request stable, then returns a one-cycle response to the owner.

Parameters:
- LINE_WIDTH, 256, cacheline width in bits.
- ADDR_WIDTH, 32, byte address width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- i_read  in  1  icache line fill request
- i_address  in  ADDR_WIDTH  icache line address
- i_rdata  out  LINE_WIDTH  fill data to icache
- i_resp  out  1  icache transaction complete (1-cycle pulse)
- d_read  in  1  dcache line fill request
- d_write  in  1  dcache line writeback request
- d_address  in  ADDR_WIDTH  dcache line address
- d_wdata  in  LINE_WIDTH  dcache writeback data
- d_rdata  out  LINE_WIDTH  fill data to dcache
- d_resp  out  1  dcache transaction complete (1-cycle pulse)
- pmem_read  out  1  memory read request
- pmem_write  out  1  memory write request
- pmem_address  out  ADDR_WIDTH  memory address
- pmem_wdata  out  LINE_WIDTH  memory write data
- pmem_rdata  in  LINE_WIDTH  memory read data
- pmem_resp  in  1  memory transaction complete

Behaviour:
- Clocking: one clock, clk. Reset rst is synchronous and active-high. All state updates occur on the rising edge of clk.
- Reset values: state=IDLE; pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0; i_resp=0, d_resp=0; i_rdata=0, d_rdata=0; owner=ICACHE; rr_last=ICACHE.
- Requester contract: a cache holds read/write, address and wdata stable from assertion until the cycle its resp is seen. It deasserts or re-issues the request in the following cycle.
- Register timing: all outputs are registered. pmem_* are driven only from the captured request registers, never combinationally from cache inputs.
- FSM states: IDLE, MEM, DONE.
- IDLE:
  - If any request is pending, select a winner by the priority rule.
  - Capture the winner's address, data (if a write) and op into pmem_address/pmem_wdata/pmem_read/pmem_write and owner.
  - Go to MEM.
  - If no request is pending, stay in IDLE with pmem_read=pmem_write=0.
- MEM:
  - Hold pmem_* constant.
  - Ignore all cache inputs; a new or changed request is not sampled.
  - On pmem_resp=1: latch pmem_rdata into the owner's rdata register (read ops only), clear pmem_read/pmem_write, go to DONE.
- DONE:
  - Assert owner's resp for exactly this one cycle; the other resp stays 0.
  - Ignore requests this cycle, so the released requester cannot be re-granted on a stale level.
  - Return to IDLE.
- Priority (default): dcache wins over icache when both are pending in the same IDLE cycle. The MEM-stage instruction is older.
- dcache op encoding: d_write=1 selects a write (pmem_write). Otherwise d_read=1 selects a read. d_read and d_write both high is illegal; write wins, and the bench flags it.
- Latency: request high in IDLE at cycle N → pmem request visible at N+1. pmem_resp at cycle M → resp high at M+1 → next grant possible at M+2.
- rdata registers: non-owner rdata is not modified by a transaction. rdata holds its value until the next read completes for that cache.
- pmem_resp outside MEM: ignored.
- Reset mid-transaction: rst in MEM or DONE forces IDLE with all reset values next cycle. The in-flight pmem transaction is abandoned, no resp is issued, and pmem must be reset concurrently.

Optional Feature:
- Macro: CACHE_ARBITER_RR_EN.
- Defined: round-robin priority. rr_last records the owner of each completed grant. On simultaneous requests, the cache that was not rr_last wins. With a single requester, that requester wins regardless of rr_last. rr_last resets to ICACHE, so the first contested grant goes to dcache.
- Undefined: fixed dcache priority as above. rr_last is not implemented.

Test Plan:
- Lone icache fill: i_read=1, i_address=0x0000_0060; pmem_resp after 3 cycles with pmem_rdata=0xA5..A5 → pmem_read=1 and pmem_address=0x60 from cycle 1; i_resp pulses 1 cycle after pmem_resp; i_rdata=0xA5..A5; d_resp stays 0.
- Dcache writeback: d_write=1, d_address=0x0000_1000, d_wdata=0x0123..EF → pmem_write=1 and pmem_wdata=0x0123..EF held until pmem_resp; d_resp pulses once; d_rdata unchanged.
- Contention (no macro): i_read and d_read raised in the same cycle → dcache is served first (pmem_address=d_address). Icache is granted in the cycle after d_resp. Both resps pulse exactly once, in order d then i.
- Contention with CACHE_ARBITER_RR_EN, both held continuously for 4 transactions → grant order d, i, d, i.
- Reset mid-operation: rst asserted 2 cycles into MEM → next cycle pmem_read=0 and state IDLE; no i_resp/d_resp; a new request after rst deasserts is granted normally.
- Request change during MEM: d_address altered while icache owns memory → pmem_address unchanged until pmem_resp; the new dcache address is granted afterward.
